// File: rtl/systolic_col_sched.sv
// Column scheduler for a systolic PE array: loads one weight word per column, feeds the
// left-edge data beats, then drains the MAC pipeline through a per-column valid delay chain.
module systolic_col_sched #(
    parameter int unsigned NUM_COL = 8,
    parameter int unsigned MAC_LAT = 2,
    parameter int unsigned KW      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         Tin_factor,
    input  logic [KW-1:0]      cfg_k_groups,
    input  logic               wt_vld,
    output logic [NUM_COL-1:0] wt_load,
    input  logic               dat_vld,
    output logic               feed_en,
    output logic [NUM_COL-1:0] col_vld,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam int unsigned CW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam int unsigned CL = MAC_LAT + NUM_COL - 1;
    localparam logic [CW-1:0] LastCol = CW'(NUM_COL - 1);

    typedef enum logic [2:0] {StIdle, StWtLoad, StFeed, StDrain, StDone} state_e;

    state_e        state;
    logic [CW-1:0] col_idx;
    logic [KW-1:0] beat_cnt;
    logic [KW-1:0] beats_q;
    logic          cfg_err_q;
    logic [CL-1:0] chain;
    logic [CL-1:0] chain_nxt;

    logic          cfg_legal;
    logic [1:0]    shamt;
    logic [KW-1:0] beats_calc;
    logic [KW-1:0] rem_mask;

    // ceil(k / Tin) as shift plus round-up on any remainder bit; cannot overflow KW bits
    always_comb begin
        cfg_legal = 1'b1;
        shamt     = 2'd0;
        unique case (Tin_factor)
            4'd1:    shamt = 2'd0;
            4'd2:    shamt = 2'd1;
            4'd4:    shamt = 2'd2;
            4'd8:    shamt = 2'd3;
            default: cfg_legal = 1'b0;
        endcase
        if (cfg_k_groups == '0) cfg_legal = 1'b0;
        rem_mask   = ~({KW{1'b1}} << shamt);
        beats_calc = (cfg_k_groups >> shamt) + KW'(|(cfg_k_groups & rem_mask));
    end

    always_comb begin
        wt_load = '0;
        if (state == StWtLoad && wt_vld) wt_load = NUM_COL'(1) << col_idx;
        feed_en = (state == StFeed) && dat_vld;
        busy    = (state != StIdle);
        done    = (state == StDone);
        cfg_err = cfg_err_q;
    end

    always_comb begin
        chain_nxt[0] = feed_en;
        for (int i = 1; i < int'(CL); i++) chain_nxt[i] = chain[i-1];
        for (int c = 0; c < int'(NUM_COL); c++) col_vld[c] = chain[MAC_LAT + c - 1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            col_idx   <= '0;
            beat_cnt  <= '0;
            beats_q   <= '0;
            cfg_err_q <= 1'b0;
            chain     <= '0;
        end else begin
            cfg_err_q <= 1'b0;
            chain     <= chain_nxt;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (cfg_legal) begin
                            beats_q <= beats_calc;
                            col_idx <= '0;
                            state   <= StWtLoad;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                StWtLoad: begin
                    if (wt_vld) begin
                        if (col_idx == LastCol) begin
                            beat_cnt <= '0;
                            state    <= StFeed;
                        end else begin
                            col_idx <= col_idx + CW'(1);
                        end
                    end
                end
                StFeed: begin
                    if (dat_vld) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if (beat_cnt == beats_q - KW'(1)) state <= StDrain;
                    end
                end
                // Leave once the chain will be empty, so DONE is the first all-quiet cycle
                StDrain: begin
                    if (chain_nxt == '0) state <= StDone;
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_col_sched.sv
// Directed bench for systolic_col_sched (NUM_COL=4, MAC_LAT=2): per-cycle expected masks.
module tb_systolic_col_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  Tin_factor = 4'd1;
    logic [15:0] cfg_k_groups = 16'd0;
    logic        wt_vld = 1'b0;
    logic        dat_vld = 1'b0;
    logic [3:0]  wt_load;
    logic        feed_en;
    logic [3:0]  col_vld;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Bit n of each mask is the value for cycle n of the current scenario
    logic [31:0] e_wt [4];
    logic [31:0] e_col [4];
    logic [31:0] e_feed, e_busy, e_done, e_err;
    logic [31:0] m_start, m_wt, m_dat, m_rst;

    systolic_col_sched #(
        .NUM_COL (4),
        .MAC_LAT (2),
        .KW      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .Tin_factor   (Tin_factor),
        .cfg_k_groups (cfg_k_groups),
        .wt_vld       (wt_vld),
        .wt_load      (wt_load),
        .dat_vld      (dat_vld),
        .feed_en      (feed_en),
        .col_vld      (col_vld),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic defaults(input logic [3:0] tin, input logic [15:0] k);
        Tin_factor   = tin;
        cfg_k_groups = k;
        m_start = 32'h1;
        m_wt    = '1;
        m_dat   = '1;
        m_rst   = '0;
        e_err   = '0;
    endtask

    // Called right after a rising edge; applies inputs and checks every cycle on the falling edge
    task automatic run(input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            #1;
            cyc     = n;
            rst_n   = !m_rst[n];
            start   = m_start[n];
            wt_vld  = m_wt[n];
            dat_vld = m_dat[n];
            @(negedge clk);
            if (!m_rst[n]) begin
                chk("wt_load", 32'(wt_load),
                    {28'd0, e_wt[3][n], e_wt[2][n], e_wt[1][n], e_wt[0][n]});
                chk("feed_en", 32'(feed_en), 32'(e_feed[n]));
                chk("col_vld", 32'(col_vld),
                    {28'd0, e_col[3][n], e_col[2][n], e_col[1][n], e_col[0][n]});
                chk("busy", 32'(busy), 32'(e_busy[n]));
                chk("done", 32'(done), 32'(e_done[n]));
                chk("cfg_err", 32'(cfg_err), 32'(e_err[n]));
            end
            @(posedge clk);
        end
        start = 1'b0;
    endtask

    task automatic set_basic_pass;
        e_wt   = '{32'h2, 32'h4, 32'h8, 32'h10};
        e_feed = 32'h0000_00E0;
        e_col  = '{32'h380, 32'h700, 32'hE00, 32'h1C00};
        e_busy = 32'h0000_3FFE;
        e_done = 32'h0000_2000;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc = -1;
        @(negedge clk);
        chk("rst_wt_load", 32'(wt_load), 32'h0);
        chk("rst_feed_en", 32'(feed_en), 32'h0);
        chk("rst_col_vld", 32'(col_vld), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_cfg_err", 32'(cfg_err), 32'h0);
        @(posedge clk);

        // Tin=1, k=3, free-running handshakes
        defaults(4'd1, 16'd3);
        set_basic_pass();
        run(16);

        // Tin=4, k=10 -> 3 beats; extra starts mid-pass and in DONE are ignored
        defaults(4'd4, 16'd10);
        m_start = 32'h0000_2009;
        set_basic_pass();
        run(16);

        // Tin=8, k=8 -> 1 beat
        defaults(4'd8, 16'd8);
        e_wt   = '{32'h2, 32'h4, 32'h8, 32'h10};
        e_feed = 32'h20;
        e_col  = '{32'h80, 32'h100, 32'h200, 32'h400};
        e_busy = 32'hFFE;
        e_done = 32'h800;
        run(14);

        // Tin=8, k=9 -> round up to 2 beats
        defaults(4'd8, 16'd9);
        e_wt   = '{32'h2, 32'h4, 32'h8, 32'h10};
        e_feed = 32'h60;
        e_col  = '{32'h180, 32'h300, 32'h600, 32'hC00};
        e_busy = 32'h1FFE;
        e_done = 32'h1000;
        run(15);

        // Data stall in cycle 6
        defaults(4'd1, 16'd3);
        m_dat  = ~32'h40;
        e_wt   = '{32'h2, 32'h4, 32'h8, 32'h10};
        e_feed = 32'h1A0;
        e_col  = '{32'h680, 32'hD00, 32'h1A00, 32'h3400};
        e_busy = 32'h7FFE;
        e_done = 32'h4000;
        run(17);

        // Illegal Tin_factor, then zero group count
        defaults(4'd3, 16'd3);
        e_wt   = '{32'h0, 32'h0, 32'h0, 32'h0};
        e_feed = '0;
        e_col  = '{32'h0, 32'h0, 32'h0, 32'h0};
        e_busy = '0;
        e_done = '0;
        e_err  = 32'h2;
        run(4);
        defaults(4'd1, 16'd0);
        e_err  = 32'h2;
        run(4);

        // Weight stall in cycles 2-3
        defaults(4'd1, 16'd3);
        m_wt   = ~32'hC;
        e_wt   = '{32'h2, 32'h10, 32'h20, 32'h40};
        e_feed = 32'h380;
        e_col  = '{32'hE00, 32'h1C00, 32'h3800, 32'h7000};
        e_busy = 32'hFFFE;
        e_done = 32'h8000;
        run(18);

        // Reset mid-FEED in cycle 6, then a fresh pass started in cycle 9
        defaults(4'd1, 16'd3);
        m_start = 32'h201;
        m_rst   = 32'h40;
        e_wt    = '{32'h402, 32'h804, 32'h1008, 32'h2010};
        e_feed  = 32'h1C020;
        e_col   = '{32'h70000, 32'hE0000, 32'h1C0000, 32'h380000};
        e_busy  = 32'h7FFC3E;
        e_done  = 32'h400000;
        run(25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_col_sched.md
SYSTOLIC_COL_SCHED -- requirements
Module: systolic_col_sched

Interface
REQ-001 Parameter NUM_COL, default 8: number of systolic PE columns sequenced.
REQ-002 Parameter MAC_LAT, default 2: cycles from column input to that column's down_dat_out being valid.
REQ-003 Parameter KW, default 16: width of the channel-group count.
REQ-004 clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 start  input  1  one-cycle request to run one pass; sampled only in IDLE.
REQ-007 Tin_factor  input  4  precision packing: 1=8bit, 2=4bit, 4=2bit, 8=1bit; sampled with start.
REQ-008 cfg_k_groups  input  KW  channel groups in the pass; sampled with start.
REQ-009 wt_vld  input  1  weight word for the current column is available.
REQ-010 wt_load  output  NUM_COL  one-hot strobe; the column whose bit is set latches the weight word.
REQ-011 dat_vld  input  1  left-edge data vector is available.
REQ-012 feed_en  output  1  left-edge data vector is consumed this cycle (doubles as data-source pop).
REQ-013 col_vld  output  NUM_COL  bit c: down_dat_out of column c is valid this cycle.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse at the end of a pass.
REQ-016 cfg_err  output  1  one-cycle pulse when start carries an illegal configuration.

Function
REQ-017 The FSM SHALL have states IDLE, WT_LOAD, FEED, DRAIN and DONE, held in one state register.
REQ-018 In IDLE, start=1 with legal config SHALL latch the config and enter WT_LOAD next cycle; start is ignored in all other states.
REQ-019 Config is legal iff Tin_factor is one of {1,2,4,8} and cfg_k_groups != 0; otherwise cfg_err pulses the next cycle and the FSM stays in IDLE.
REQ-020 Beat count SHALL be ceil(cfg_k_groups / Tin_factor), computed by shift and round-up, KW bits wide, no overflow for any legal input.
REQ-021 WT_LOAD: wt_load = one-hot(col_idx) when wt_vld=1, else 0; col_idx starts at 0 and advances only on wt_vld=1.
REQ-022 After the strobe for column NUM_COL-1, the FSM SHALL enter FEED next cycle with beat counter cleared.
REQ-023 FEED: feed_en = dat_vld; the beat counter increments on each feed_en; a stall (dat_vld=0) inserts a bubble without advancing.
REQ-024 When the final beat is fed, the FSM SHALL enter DRAIN next cycle; feed_en SHALL never exceed the beat count.
REQ-025 col_vld[c] SHALL equal feed_en delayed by exactly MAC_LAT+c cycles, via a registered shift chain that keeps running in DRAIN.
REQ-026 DRAIN SHALL exit to DONE in the first cycle in which the whole delay chain and col_vld are zero.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 wt_load, feed_en, done and cfg_err SHALL be 0 in every state other than the one that drives them.

Reset
REQ-029 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear the latched config, counters and delay chain, from any state, including mid-pass.
REQ-030 After reset, all outputs (wt_load, feed_en, col_vld, busy, done, cfg_err) SHALL read 0 until a new legal start.

Verification
Conditions for all scenarios: NUM_COL=4, MAC_LAT=2, start pulsed in cycle 0.
REQ-031 Tin=1, k=3, wt_vld/dat_vld tied 1 -> wt_load 0001,0010,0100,1000 in cycles 1-4; feed_en in cycles 5-7; col_vld[0] in 7-9; col_vld[3] in 10-12; done in 13; busy high in 1-13.
REQ-032 Tin=4, k=10 -> exactly 3 feed_en beats; Tin=8, k=8 -> exactly 1 beat.
REQ-033 Tin=1, k=3, dat_vld=0 in cycle 6 only -> feed_en in 5,7,8; col_vld[0] in 7,9,10 with a gap at 8; done in 14.
REQ-034 Start with Tin=3 or with k=0 -> cfg_err in cycle 1; busy stays 0; no wt_load.
REQ-035 wt_vld=0 in cycles 2-3 -> wt_load 0010 is delayed to cycle 4; all later events shift by 2.
REQ-036 rst_n=0 in cycle 6 of REQ-031 -> all outputs 0 from cycle 7; start in cycle 9 runs a full normal pass.
